// File: rtl/mips_control_register_scoreboard_pkg.sv
// Shared definitions for the register scoreboard.
// Holds the register-file geometry (5-bit addresses, 32 registers), the
// address and writeback-decrement types used on the block's ports, and the
// helper that sizes a per-register pending counter from MAX_PENDING.
package mips_control_register_scoreboard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // Number of writebacks retiring one register in a cycle (0..2).
    typedef logic [1:0] wb_dec_t;

    // Counter width able to hold 0..max_pending.
    function automatic int cnt_width(input int max_pending);
        return $clog2(max_pending + 1);
    endfunction

endpackage

// File: rtl/mips_control_register_scoreboard_counter.sv
// Pending-write counter for one architectural register.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   clear_i        : synchronous clear (flush); overrides inc_i/dec_i
//   inc_i          : one write issued to this register this cycle
//   dec_i          : number of writebacks retiring this register (0..2)
//   count_o        : registered pending count
//   underflow_o    : this cycle retires more writes than are pending
//                    (count saturates at zero instead of wrapping)
module mips_control_register_scoreboard_counter
    import mips_control_register_scoreboard_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             inc_i,
    input  wb_dec_t          dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             underflow_o
);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;
    // One extra bit so count+inc and the underflow compare never wrap.
    logic [CNT_W:0]   sum_s;
    logic [CNT_W:0]   dec_ext_s;
    logic [CNT_W:0]   diff_s;

    // Next count: net of issue and writebacks, floored at zero.
    always_comb begin
        sum_s          = {1'b0, count_q} + {{CNT_W{1'b0}}, inc_i};
        dec_ext_s      = {(CNT_W+1){1'b0}};
        dec_ext_s[1:0] = dec_i;
        diff_s         = sum_s - dec_ext_s;
        count_d        = count_q;
        underflow_o    = 1'b0;
        if (clear_i) begin
            count_d = {CNT_W{1'b0}};
        end else if (dec_ext_s > sum_s) begin
            count_d     = {CNT_W{1'b0}};
            underflow_o = 1'b1;
        end else begin
            count_d = diff_s[CNT_W-1:0];
        end
    end

    // Counter state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/mips_control_register_scoreboard.sv
// Register scoreboard for an in-order MIPS pipeline.
// Tracks, per architectural register 1..31, how many issued writes have not
// yet written back, and blocks issue of an instruction that reads a register
// with a pending write or would overflow the destination's pending count.
// Ports:
//   clock, reset_n                    : clock, asynchronous active-low reset
//   issueValid / issueReady           : decode handshake (fire = both high)
//   issuePort{1,2}Addr/Used           : source registers actually read
//   issueWriteEnable / issueWriteAddr : destination register of the issue
//   wbAluValid/Addr, wbMemValid/Addr  : writebacks, each retires one write
//   flush                             : discard every in-flight write
//   pendingMask                       : bit r set while register r pending
//   stall                             : issueValid & ~issueReady
//   errUnderflow                      : sticky, a writeback found nothing pending
module mips_control_register_scoreboard
    import mips_control_register_scoreboard_pkg::*;
#(
    parameter int MAX_PENDING = 3
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 issueValid,
    output logic                 issueReady,
    input  logic [REG_ADDR_W-1:0] issuePort1Addr,
    input  logic [REG_ADDR_W-1:0] issuePort2Addr,
    input  logic                 issuePort1Used,
    input  logic                 issuePort2Used,
    input  logic                 issueWriteEnable,
    input  logic [REG_ADDR_W-1:0] issueWriteAddr,
    input  logic                 wbAluValid,
    input  logic [REG_ADDR_W-1:0] wbAluAddr,
    input  logic                 wbMemValid,
    input  logic [REG_ADDR_W-1:0] wbMemAddr,
    input  logic                 flush,
    output logic [REG_COUNT-1:0] pendingMask,
    output logic                 stall,
    output logic                 errUnderflow
);

    localparam int               CNT_W    = cnt_width(MAX_PENDING);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_PENDING);

    logic [CNT_W-1:0]     count_s [REG_COUNT];
    logic [REG_COUNT-1:1] underflow_s;
    logic [REG_COUNT-1:0] pending_mask_s;
    logic                 hazard_s;
    logic                 ready_s;
    logic                 fire_s;
    logic                 err_underflow_d;
    logic                 err_underflow_q;

    // r0 is hardwired zero and never has a pending write.
    assign count_s[0]        = CNT_ZERO;
    assign pending_mask_s[0] = 1'b0;

    // Hazard looks only at registered counts, so a writeback in this cycle
    // unblocks issue one cycle later.
    always_comb begin
        hazard_s = (issuePort1Used & (count_s[issuePort1Addr] != CNT_ZERO))
                 | (issuePort2Used & (count_s[issuePort2Addr] != CNT_ZERO))
                 | (issueWriteEnable & (issueWriteAddr != 5'd0)
                    & (count_s[issueWriteAddr] == CNT_MAX));
        ready_s  = ~hazard_s & ~flush;
        fire_s   = issueValid & ready_s;
    end

    for (genvar r = 1; r < REG_COUNT; r++) begin : g_reg
        localparam reg_addr_t R_ADDR = reg_addr_t'(r);

        logic    inc_s;
        logic    alu_hit_s;
        logic    mem_hit_s;
        wb_dec_t dec_s;

        assign inc_s     = fire_s & issueWriteEnable & (issueWriteAddr == R_ADDR);
        assign alu_hit_s = wbAluValid & (wbAluAddr == R_ADDR);
        assign mem_hit_s = wbMemValid & (wbMemAddr == R_ADDR);
        assign dec_s     = {1'b0, alu_hit_s} + {1'b0, mem_hit_s};

        mips_control_register_scoreboard_counter #(
            .CNT_W (CNT_W)
        ) u_counter (
            .clock       (clock),
            .reset_n     (reset_n),
            .clear_i     (flush),
            .inc_i       (inc_s),
            .dec_i       (dec_s),
            .count_o     (count_s[r]),
            .underflow_o (underflow_s[r])
        );

        assign pending_mask_s[r] = (count_s[r] != CNT_ZERO);
    end

    // Underflow is sticky until reset; a flush clears counters only.
    always_comb begin
        err_underflow_d = err_underflow_q | (|underflow_s);
    end

    // Sticky underflow flag register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_underflow_q <= 1'b0;
        end else begin
            err_underflow_q <= err_underflow_d;
        end
    end

    assign issueReady   = ready_s;
    assign stall        = issueValid & ~ready_s;
    assign pendingMask  = pending_mask_s;
    assign errUnderflow = err_underflow_q;

endmodule

// File: tb/tb_mips_control_register_scoreboard.sv
module tb_mips_control_register_scoreboard;

    localparam int MAXP = 3;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        issueValid, issueReady;
    logic [4:0]  issuePort1Addr, issuePort2Addr, issueWriteAddr;
    logic        issuePort1Used, issuePort2Used, issueWriteEnable;
    logic        wbAluValid, wbMemValid, flush;
    logic [4:0]  wbAluAddr, wbMemAddr;
    logic [31:0] pendingMask;
    logic        stall, errUnderflow;

    int vectors = 0;
    int miscompares = 0;
    int cnt [32];   // reference pending count per register
    bit merr;       // reference sticky underflow

    always #5 clock = ~clock;

    mips_control_register_scoreboard #(.MAX_PENDING(MAXP)) dut (
        .clock(clock), .reset_n(reset_n),
        .issueValid(issueValid), .issueReady(issueReady),
        .issuePort1Addr(issuePort1Addr), .issuePort2Addr(issuePort2Addr),
        .issuePort1Used(issuePort1Used), .issuePort2Used(issuePort2Used),
        .issueWriteEnable(issueWriteEnable), .issueWriteAddr(issueWriteAddr),
        .wbAluValid(wbAluValid), .wbAluAddr(wbAluAddr),
        .wbMemValid(wbMemValid), .wbMemAddr(wbMemAddr),
        .flush(flush), .pendingMask(pendingMask),
        .stall(stall), .errUnderflow(errUnderflow)
    );

    function automatic bit m_ready();
        bit h;
        h = (issuePort1Used && cnt[issuePort1Addr] != 0)
         || (issuePort2Used && cnt[issuePort2Addr] != 0)
         || (issueWriteEnable && issueWriteAddr != 0 && cnt[issueWriteAddr] == MAXP);
        return !h && !flush;
    endfunction

    function automatic logic [31:0] m_mask();
        logic [31:0] m;
        m = 32'd0;
        for (int r = 1; r < 32; r++) m[r] = (cnt[r] != 0);
        return m;
    endfunction

    task automatic m_reset();
        for (int r = 0; r < 32; r++) cnt[r] = 0;
        merr = 1'b0;
    endtask

    // Advance one clock edge and apply the reference update rules.
    task automatic tick();
        bit rdy;
        int n;
        rdy = m_ready();
        @(posedge clock);
        if (flush) begin
            for (int r = 0; r < 32; r++) cnt[r] = 0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                n = cnt[r];
                if (issueValid && rdy && issueWriteEnable && issueWriteAddr == r) n = n + 1;
                if (wbAluValid && wbAluAddr == r) n = n - 1;
                if (wbMemValid && wbMemAddr == r) n = n - 1;
                if (n < 0) begin n = 0; merr = 1'b1; end
                cnt[r] = n;
            end
        end
        #1;
    endtask

    task automatic idle();
        issueValid = 0; issuePort1Used = 0; issuePort2Used = 0; issueWriteEnable = 0;
        issuePort1Addr = 0; issuePort2Addr = 0; issueWriteAddr = 0;
        wbAluValid = 0; wbAluAddr = 0; wbMemValid = 0; wbMemAddr = 0; flush = 0;
    endtask

    task automatic issue_write(input int a);
        idle(); issueValid = 1; issueWriteEnable = 1; issueWriteAddr = 5'(a);
    endtask

    task automatic issue_read(input int a);
        idle(); issueValid = 1; issuePort1Used = 1; issuePort1Addr = 5'(a);
    endtask

    task automatic clear_all();
        idle(); flush = 1; tick(); idle();
    endtask

    task automatic test_reset();
        idle();
        #1 reset_n = 0;
        issue_write(5); issuePort1Used = 1; issuePort1Addr = 5'd5;
        #2;
        vectors++; if (pendingMask !== 32'd0) begin miscompares++; $display("FAIL reset_mask got %h want %h", pendingMask, 32'd0); end
        vectors++; if (errUnderflow !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", errUnderflow); end
        vectors++; if (issueReady !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", issueReady); end
        repeat (2) @(posedge clock);
        #1 reset_n = 1; idle(); m_reset();
    endtask

    task automatic test_raw_and_wb();
        clear_all();
        issue_write(5); #2;
        vectors++; if (issueReady !== 1'b1) begin miscompares++; $display("FAIL raw_wr_ready got %b want 1", issueReady); end
        tick();
        issue_read(5); #2;
        vectors++; if (issueReady !== 1'b0) begin miscompares++; $display("FAIL raw_ready got %b want 0", issueReady); end
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL raw_stall got %b want 1", stall); end
        vectors++; if (pendingMask[5] !== 1'b1) begin miscompares++; $display("FAIL raw_mask5 got %b want 1", pendingMask[5]); end
        wbAluValid = 1; wbAluAddr = 5'd5; #1;
        vectors++; if (issueReady !== 1'b0) begin miscompares++; $display("FAIL wb_same_cycle_ready got %b want 0", issueReady); end
        tick();
        wbAluValid = 0; #2;
        vectors++; if (issueReady !== 1'b1) begin miscompares++; $display("FAIL wb_next_ready got %b want 1", issueReady); end
        vectors++; if (pendingMask[5] !== 1'b0) begin miscompares++; $display("FAIL wb_next_mask5 got %b want 0", pendingMask[5]); end
        tick();
    endtask

    task automatic test_max_pending();
        clear_all();
        for (int i = 0; i < MAXP; i++) begin
            issue_write(7); #2;
            vectors++; if (issueReady !== 1'b1) begin miscompares++; $display("FAIL max_fill%0d got %b want 1", i, issueReady); end
            tick();
        end
        issue_write(7); #2;
        vectors++; if (issueReady !== 1'b0) begin miscompares++; $display("FAIL max_full_ready got %b want 0", issueReady); end
        issue_read(8); #2;
        vectors++; if (issueReady !== 1'b1) begin miscompares++; $display("FAIL max_r8_ready got %b want 1", issueReady); end
        issue_write(7); wbMemValid = 1; wbMemAddr = 5'd7; #2;
        vectors++; if (issueReady !== 1'b0) begin miscompares++; $display("FAIL max_wb_same got %b want 0", issueReady); end
        tick();
        issue_write(7); #2;
        vectors++; if (issueReady !== 1'b1) begin miscompares++; $display("FAIL max_after_wb got %b want 1", issueReady); end
        tick(); idle();
    endtask

    task automatic test_double_wb();
        clear_all();
        issue_write(9); tick(); issue_write(9); tick();
        idle(); wbAluValid = 1; wbAluAddr = 5'd9; wbMemValid = 1; wbMemAddr = 5'd9; tick();
        idle(); #2;
        vectors++; if (pendingMask[9] !== 1'b0) begin miscompares++; $display("FAIL dbl2_mask9 got %b want 0", pendingMask[9]); end
        vectors++; if (errUnderflow !== 1'b0) begin miscompares++; $display("FAIL dbl2_err got %b want 0", errUnderflow); end
        issue_write(9); tick();
        idle(); wbAluValid = 1; wbAluAddr = 5'd9; wbMemValid = 1; wbMemAddr = 5'd9; tick();
        idle(); #2;
        vectors++; if (pendingMask[9] !== 1'b0) begin miscompares++; $display("FAIL dbl1_mask9 got %b want 0", pendingMask[9]); end
        vectors++; if (errUnderflow !== 1'b1) begin miscompares++; $display("FAIL dbl1_err got %b want 1", errUnderflow); end
        tick(); tick();
        vectors++; if (errUnderflow !== 1'b1) begin miscompares++; $display("FAIL err_sticky got %b want 1", errUnderflow); end
    endtask

    task automatic test_reg_zero();
        clear_all();
        issue_write(0); issuePort1Used = 1; issuePort2Used = 1;
        wbAluValid = 1; wbMemValid = 1; #2;
        vectors++; if (issueReady !== 1'b1) begin miscompares++; $display("FAIL r0_ready got %b want 1", issueReady); end
        tick(); tick(); #1;
        vectors++; if (pendingMask !== 32'd0) begin miscompares++; $display("FAIL r0_mask got %h want 0", pendingMask); end
        vectors++; if (errUnderflow !== merr) begin miscompares++; $display("FAIL r0_err got %b want %b", errUnderflow, merr); end
        idle();
    endtask

    task automatic test_flush();
        clear_all();
        issue_write(3); tick(); issue_write(4); tick();
        idle(); #2;
        vectors++; if (pendingMask !== 32'h0000_0018) begin miscompares++; $display("FAIL fl_pre_mask got %h want 00000018", pendingMask); end
        issue_write(10); flush = 1; #2;
        vectors++; if (issueReady !== 1'b0) begin miscompares++; $display("FAIL fl_ready got %b want 0", issueReady); end
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL fl_stall got %b want 1", stall); end
        tick(); idle(); #1;
        vectors++; if (pendingMask !== 32'd0) begin miscompares++; $display("FAIL fl_mask got %h want 0", pendingMask); end
    endtask

    task automatic test_reset_mid();
        clear_all();
        issue_write(6); tick();
        issue_read(6); #2;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL rm_stall got %b want 1", stall); end
        #1 reset_n = 0; #1;
        vectors++; if (pendingMask !== 32'd0) begin miscompares++; $display("FAIL rm_mask got %h want 0", pendingMask); end
        vectors++; if (errUnderflow !== 1'b0) begin miscompares++; $display("FAIL rm_err got %b want 0", errUnderflow); end
        vectors++; if (issueReady !== 1'b1) begin miscompares++; $display("FAIL rm_ready got %b want 1", issueReady); end
        m_reset();
        #1 reset_n = 1;
        tick(); idle();
    endtask

    task automatic test_random();
        bit er;
        for (int i = 0; i < 400; i++) begin
            issueValid       = 1'($urandom_range(0, 1));
            issuePort1Used   = 1'($urandom_range(0, 1));
            issuePort2Used   = 1'($urandom_range(0, 1));
            issueWriteEnable = 1'($urandom_range(0, 3) != 0);
            issuePort1Addr   = 5'($urandom_range(0, 7));
            issuePort2Addr   = 5'($urandom_range(0, 7));
            issueWriteAddr   = (i % 50 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
            wbAluValid       = 1'($urandom_range(0, 2) == 0);
            wbAluAddr        = 5'($urandom_range(0, 5));
            wbMemValid       = 1'($urandom_range(0, 3) == 0);
            wbMemAddr        = 5'($urandom_range(0, 5));
            flush            = 1'($urandom_range(0, 29) == 0);
            #2;
            er = m_ready();
            vectors++; if (issueReady !== er) begin miscompares++; $display("FAIL rnd_ready cyc %0d got %b want %b", i, issueReady, er); end
            vectors++; if (stall !== (issueValid & ~er)) begin miscompares++; $display("FAIL rnd_stall cyc %0d got %b want %b", i, stall, issueValid & ~er); end
            vectors++; if (pendingMask !== m_mask()) begin miscompares++; $display("FAIL rnd_mask cyc %0d got %h want %h", i, pendingMask, m_mask()); end
            vectors++; if (errUnderflow !== merr) begin miscompares++; $display("FAIL rnd_err cyc %0d got %b want %b", i, errUnderflow, merr); end
            tick();
        end
        idle();
    endtask

    initial begin
        m_reset();
        test_reset();
        test_raw_and_wb();
        test_max_pending();
        test_double_wb();
        test_reg_zero();
        test_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
